// File: rtl/z80tube_bridge.sv
// z80tube_bridge: bridges a Z80 host I/O cycle onto a 6502-style Tube bus
// and provides a small block of host-visible status registers.
//   CLK, RESET_B            : host clock, asynchronous active-low reset
//   ADR, RD_B, WR_B,
//   IOREQ_B, M1_B, DATA     : Z80 host bus (DATA bidirectional)
//   WAIT_B, INT_B, NMI_B    : open-drain host wait/interrupt lines
//   TUBE_ADR, TUBE_DATA,
//   TUBE_RNW_B, TUBE_PHI2,
//   TUBE_CS_B, TUBE_INT_B   : Tube-side bus and interrupt request
module z80tube_bridge #(
  parameter logic [11:0] TUBE_BASE = 12'hFA8,
  parameter logic [15:0] STAT_ADR  = 16'hFFF9,
  parameter int unsigned NSTAT     = 1,
  parameter int unsigned PHI2_CYC  = 1
) (
  input  logic        CLK,
  input  logic        RESET_B,
  input  logic [15:0] ADR,
  input  logic        RD_B,
  input  logic        WR_B,
  input  logic        IOREQ_B,
  input  logic        M1_B,
  inout  logic [7:0]  DATA,
  output logic        WAIT_B,
  inout  logic        INT_B,
  inout  logic        NMI_B,
  input  logic        TUBE_INT_B,
  inout  logic [7:0]  TUBE_DATA,
  output logic [15:0] TUBE_ADR,
  output logic        TUBE_RNW_B,
  output logic        TUBE_PHI2,
  output logic        TUBE_CS_B
);

  typedef enum logic [1:0] {IDLE, SETUP, PHI2H, HOLD} state_e;

  localparam logic [2:0] CNT_LAST = 3'(PHI2_CYC - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       phi2_q, phi2_d;
  logic       wr_q, wr_d;
  logic [7:0] rd_lat_q, rd_lat_d;
  logic [7:0] stat_q [NSTAT];
  logic [7:0] stat_d [NSTAT];

  logic       io_cyc, tube_sel, tube_acc;
  logic       wait_drv, hold_rd, stat_rd;
  logic [7:0] stat_val;

  // M1_B low with IOREQ_B low is an interrupt acknowledge, not an I/O cycle.
  assign io_cyc   = !IOREQ_B && M1_B;
  assign tube_sel = io_cyc && (ADR[15:4] == TUBE_BASE);
  assign tube_acc = tube_sel && (!RD_B || !WR_B);

  assign TUBE_ADR   = ADR;
  assign TUBE_CS_B  = !tube_sel;
  assign TUBE_RNW_B = IOREQ_B || WR_B;
  assign TUBE_PHI2  = phi2_q;

  // Direction is latched at access start so PHI2H still drives/captures
  // correctly if the host drops its strobes before the pulse completes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    rd_lat_d = rd_lat_q;
    case (state_q)
      IDLE: begin
        if (tube_acc) begin
          state_d = SETUP;
          wr_d    = !WR_B;
          cnt_d   = '0;
        end
      end
      SETUP: begin
        state_d = PHI2H;
        cnt_d   = '0;
      end
      PHI2H: begin
        if (cnt_q == CNT_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
          if (!wr_q) rd_lat_d = TUBE_DATA;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      HOLD: begin
        if (IOREQ_B) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    phi2_d = (state_d == PHI2H);
  end

  always_comb begin
    stat_d   = stat_q;
    stat_rd  = 1'b0;
    stat_val = '0;
    for (int unsigned i = 0; i < NSTAT; i++) begin
      if (io_cyc && (ADR == 16'(STAT_ADR + i))) begin
        if (!WR_B) stat_d[i] = DATA;
        if (!RD_B) begin
          stat_rd  = 1'b1;
          // Bit 7 of register 0 reflects the live Tube interrupt request.
          stat_val = (i == 0) ? {!TUBE_INT_B, stat_q[i][6:0]} : stat_q[i];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      phi2_q   <= 1'b0;
      wr_q     <= 1'b0;
      rd_lat_q <= '0;
      for (int unsigned i = 0; i < NSTAT; i++) stat_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phi2_q   <= phi2_d;
      wr_q     <= wr_d;
      rd_lat_q <= rd_lat_d;
      stat_q   <= stat_d;
    end
  end

  // RESET_B gating keeps the combinational terms from driving during reset.
  assign wait_drv = RESET_B && ((state_q == IDLE && tube_acc) ||
                                state_q == SETUP || state_q == PHI2H);
  assign hold_rd  = (state_q == HOLD) && !RD_B && io_cyc;

  assign WAIT_B    = wait_drv ? 1'b0 : 1'bz;
  assign DATA      = (RESET_B && hold_rd) ? rd_lat_q :
                     (RESET_B && stat_rd) ? stat_val : 8'bzzzz_zzzz;
  assign TUBE_DATA = (state_q == PHI2H && wr_q) ? DATA : 8'bzzzz_zzzz;
  assign INT_B     = (!TUBE_INT_B && stat_q[0][0]) ? 1'b0 : 1'bz;
  assign NMI_B     = 1'bz;

endmodule

// File: tb/tb_z80tube_bridge.sv
// Directed bench for z80tube_bridge. Two instances share the host strobes:
// u_dut1 (PHI2_CYC=1, NSTAT=1) and u_dut3 (PHI2_CYC=3, NSTAT=2), each with
// its own pulled-up data, Tube and open-drain nets so Z reads back as 1.
module tb_z80tube_bridge;

  logic        clk, rst_n;
  logic [15:0] adr;
  logic        rd_b, wr_b, ioreq_b, m1_b, tube_int_b;
  logic [7:0]  host_drv, tube_val;
  logic        host_en, tube_en;

  tri1 [7:0]   data1, data3, tdata1, tdata3;
  tri1         wait1, wait3, int1, int3, nmi1, nmi3;
  logic [15:0] tadr1, tadr3;
  logic        rnw1, rnw3, phi1, phi3, cs1, cs3;

  assign data1  = host_en ? host_drv : 8'bzzzz_zzzz;
  assign data3  = host_en ? host_drv : 8'bzzzz_zzzz;
  assign tdata1 = (tube_en && rnw1) ? tube_val : 8'bzzzz_zzzz;
  assign tdata3 = (tube_en && rnw3) ? tube_val : 8'bzzzz_zzzz;

  z80tube_bridge #(.TUBE_BASE(12'hFA8), .STAT_ADR(16'hFFF9), .NSTAT(1), .PHI2_CYC(1)) u_dut1 (
    .CLK(clk), .RESET_B(rst_n), .ADR(adr), .RD_B(rd_b), .WR_B(wr_b),
    .IOREQ_B(ioreq_b), .M1_B(m1_b), .DATA(data1), .WAIT_B(wait1),
    .INT_B(int1), .NMI_B(nmi1), .TUBE_INT_B(tube_int_b), .TUBE_DATA(tdata1),
    .TUBE_ADR(tadr1), .TUBE_RNW_B(rnw1), .TUBE_PHI2(phi1), .TUBE_CS_B(cs1)
  );

  z80tube_bridge #(.TUBE_BASE(12'hFA8), .STAT_ADR(16'hFFF9), .NSTAT(2), .PHI2_CYC(3)) u_dut3 (
    .CLK(clk), .RESET_B(rst_n), .ADR(adr), .RD_B(rd_b), .WR_B(wr_b),
    .IOREQ_B(ioreq_b), .M1_B(m1_b), .DATA(data3), .WAIT_B(wait3),
    .INT_B(int3), .NMI_B(nmi3), .TUBE_INT_B(tube_int_b), .TUBE_DATA(tdata3),
    .TUBE_ADR(tadr3), .TUBE_RNW_B(rnw3), .TUBE_PHI2(phi3), .TUBE_CS_B(cs3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Per-window measurements filled in by measure().
  int         w1, w3, p1, p3, r3;
  logic       prev3;
  logic [7:0] td1_phi, last_d1, last_d3;

  task automatic idle_bus();
    ioreq_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1; m1_b = 1'b1;
    host_en = 1'b0; tube_en = 1'b0;
  endtask

  // Samples n cycles starting just after a falling edge; optionally releases
  // the host strobes right after sample index rel_at.
  task automatic measure(input int n, input int rel_at);
    w1 = 0; w3 = 0; p1 = 0; p3 = 0; r3 = 0; prev3 = 1'b0; td1_phi = 8'h00;
    for (int k = 0; k < n; k++) begin
      #1;
      if (!wait1) w1++;
      if (!wait3) w3++;
      if (phi1) begin p1++; td1_phi = tdata1; end
      if (phi3) p3++;
      if (phi3 && !prev3) r3++;
      prev3   = phi3;
      last_d1 = data1;
      last_d3 = data3;
      if (k == rel_at) begin
        ioreq_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1; host_en = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] v);
    @(negedge clk);
    adr = a; host_drv = v; host_en = 1'b1; ioreq_b = 1'b0; wr_b = 1'b0;
    #1 check("stat_wr_nowait", {15'd0, wait3}, 16'h0001);
    @(negedge clk);
    idle_bus();
  endtask

  task automatic io_read(input logic [15:0] a, output logic [7:0] d1, output logic [7:0] d3);
    @(negedge clk);
    adr = a; ioreq_b = 1'b0; rd_b = 1'b0;
    #1;
    d1 = data1;
    d3 = data3;
    @(negedge clk);
    idle_bus();
  endtask

  logic [7:0] rd1, rd3;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; adr = 16'h0000; tube_int_b = 1'b1;
    host_drv = 8'h00; tube_val = 8'h00;
    idle_bus();
    #3;
    check("rst_wait_z",  {15'd0, wait3}, 16'h0001);
    check("rst_phi2",    {15'd0, phi3},  16'h0000);
    check("rst_data_z",  {8'd0, data3},  16'h00FF);
    check("rst_tdata_z", {8'd0, tdata3}, 16'h00FF);
    check("rst_int_z",   {15'd0, int3},  16'h0001);
    check("nmi_z",       {15'd0, nmi3},  16'h0001);
    @(negedge clk);
    rst_n = 1'b1;

    // Interrupt gating
    tube_int_b = 1'b0;
    #1 check("int_gate_off", {15'd0, int3}, 16'h0001);
    io_write(16'hFFF9, 8'h01);
    #1 check("int_gate_on", {15'd0, int3}, 16'h0000);
    tube_int_b = 1'b1;
    #1 check("int_req_off", {15'd0, int3}, 16'h0001);

    // Status registers
    io_write(16'hFFF9, 8'h81);
    io_write(16'hFFFA, 8'h7E);
    io_read(16'hFFF9, rd1, rd3);
    check("stat0_rd", {8'd0, rd3}, 16'h0001);
    io_read(16'hFFFA, rd1, rd3);
    check("stat1_rd", {8'd0, rd3}, 16'h007E);
    check("nstat1_no_reg1", {8'd0, rd1}, 16'h00FF);
    tube_int_b = 1'b0;
    io_read(16'hFFF9, rd1, rd3);
    check("stat0_int_rd", {8'd0, rd3}, 16'h0081);
    check("stat0_int_rd1", {8'd0, rd1}, 16'h0081);
    tube_int_b = 1'b1;

    // Tube write, OUT (FA81),5A
    @(negedge clk);
    adr = 16'hFA81; host_drv = 8'h5A; host_en = 1'b1; ioreq_b = 1'b0; wr_b = 1'b0;
    #1;
    check("wr_cs",   {15'd0, cs1},  16'h0000);
    check("wr_rnw",  {15'd0, rnw1}, 16'h0000);
    check("wr_tadr", tadr1, 16'hFA81);
    measure(8, -1);
    check("wr_wait_cycles", 16'(w1), 16'd3);
    check("wr_phi2_cycles", 16'(p1), 16'd1);
    check("wr_tdata",       {8'd0, td1_phi}, 16'h005A);
    check("wr_phi2_cyc3",   16'(p3), 16'd3);
    idle_bus();

    // Tube read, Tube returns C3
    @(negedge clk);
    adr = 16'hFA80; ioreq_b = 1'b0; rd_b = 1'b0; tube_en = 1'b1; tube_val = 8'hC3;
    #1 check("rd_rnw", {15'd0, rnw3}, 16'h0001);
    measure(8, -1);
    check("rd_phi2_cycles", 16'(p3), 16'd3);
    check("rd_phi2_pulses", 16'(r3), 16'd1);
    check("rd_wait_cycles", 16'(w3), 16'd5);
    check("rd_hold_data3",  {8'd0, last_d3}, 16'h00C3);
    check("rd_hold_data1",  {8'd0, last_d1}, 16'h00C3);
    idle_bus();
    #1 check("rd_release_z", {8'd0, data3}, 16'h00FF);

    // Early IOREQ_B release during PHI2H
    @(negedge clk);
    adr = 16'hFA80; ioreq_b = 1'b0; rd_b = 1'b0; tube_en = 1'b1; tube_val = 8'h3C;
    measure(8, 2);
    check("abort_phi2_cycles", 16'(p3), 16'd3);
    check("abort_phi2_pulses", 16'(r3), 16'd1);
    check("abort_wait_cycles", 16'(w3), 16'd5);
    check("abort_end_wait_z",  {15'd0, wait3}, 16'h0001);
    idle_bus();

    // Interrupt acknowledge at Tube address
    adr = 16'hFA80; ioreq_b = 1'b0; m1_b = 1'b0; rd_b = 1'b0;
    #1;
    check("m1_wait_z", {15'd0, wait3}, 16'h0001);
    check("m1_cs",     {15'd0, cs3},   16'h0001);
    measure(5, -1);
    check("m1_no_wait", 16'(w3), 16'd0);
    check("m1_no_phi2", 16'(p3), 16'd0);
    idle_bus();

    // Reset during PHI2H
    adr = 16'hFA80; ioreq_b = 1'b0; rd_b = 1'b0; tube_en = 1'b1; tube_val = 8'h55;
    measure(3, -1);
    #1 check("pre_rst_phi2", {15'd0, phi3}, 16'h0001);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_phi2",   {15'd0, phi3},  16'h0000);
    check("rst_mid_wait_z", {15'd0, wait3}, 16'h0001);
    check("rst_mid_cs",     {15'd0, cs3},   16'h0000);
    check("rst_mid_data_z", {8'd0, data3},  16'h00FF);
    idle_bus();
    @(negedge clk);
    rst_n = 1'b1;
    io_read(16'hFFF9, rd1, rd3);
    check("rst_stat0", {8'd0, rd3}, 16'h0000);
    io_read(16'hFFFA, rd1, rd3);
    check("rst_stat1", {8'd0, rd3}, 16'h0000);
    measure(3, -1);
    check("rst_no_restart", 16'(p3), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/z80tube_bridge.md
Z80TUBE_BRIDGE -- requirements
Module: z80tube_bridge

Interface
REQ-001 SHALL have parameter TUBE_BASE, default 12'hFA8: ADR[15:4] match value for Tube chip select.
REQ-002 SHALL have parameter STAT_ADR, default 16'hFFF9: address of status register 0.
REQ-003 SHALL have parameter NSTAT, default 1, range 1..4: number of status registers, at STAT_ADR+0..NSTAT-1.
REQ-004 SHALL have parameter PHI2_CYC, default 1, range 1..8: CLK cycles TUBE_PHI2 stays high per access.
REQ-005 SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port CLK, input, 1: host clock; all state changes on its rising edge.
REQ-007 SHALL have port RESET_B, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port ADR, input, 16: host address.
REQ-009 SHALL have ports RD_B, WR_B, IOREQ_B, M1_B, each input, 1: host strobes, active low.
REQ-010 SHALL have port DATA, inout, 8: host data bus.
REQ-011 SHALL have port WAIT_B, output, 1: open-drain wait; drives 0 or Z.
REQ-012 SHALL have ports INT_B and NMI_B, inout, 1: open-drain interrupts; NMI_B is always Z.
REQ-013 SHALL have port TUBE_INT_B, input, 1: Tube interrupt request, active low.
REQ-014 SHALL have port TUBE_DATA, inout, 8: Tube data bus.
REQ-015 SHALL have port TUBE_ADR, output, 16: equal to ADR at all times.
REQ-016 SHALL have ports TUBE_RNW_B, TUBE_PHI2 and TUBE_CS_B, each output, 1.

Function
REQ-017 SHALL define io_cyc as !IOREQ_B & M1_B, so interrupt-acknowledge cycles (M1_B low) are ignored.
REQ-018 SHALL define tube_acc as io_cyc & (ADR[15:4]==TUBE_BASE) & (!RD_B | !WR_B).
REQ-019 SHALL define TUBE_CS_B = !(io_cyc & (ADR[15:4]==TUBE_BASE)) and TUBE_RNW_B = IOREQ_B | WR_B, both combinational.
REQ-020 SHALL implement FSM states IDLE, SETUP, PHI2H, HOLD:
- IDLE -> SETUP when tube_acc is 1.
- SETUP -> PHI2H after exactly 1 cycle.
- PHI2H -> HOLD after PHI2_CYC cycles.
- HOLD -> IDLE when IOREQ_B is 1.
REQ-021 SHALL drive TUBE_PHI2 directly from a register: 1 only in PHI2H, so it is glitch-free with high time of exactly PHI2_CYC cycles.
REQ-022 SHALL drive WAIT_B to 0 combinationally when (IDLE & tube_acc), in SETUP, and in PHI2H, and to Z otherwise.
REQ-023 SHALL drive TUBE_DATA = DATA in PHI2H when the access is a write, and Z otherwise.
REQ-024 SHALL capture TUBE_DATA into an 8-bit read latch on the last PHI2H cycle of a read access.
REQ-025 SHALL drive DATA from the read latch in HOLD while !RD_B & io_cyc.
REQ-026 SHALL not truncate PHI2H if IOREQ_B rises early: the FSM completes PHI2H, passes through HOLD for 1 cycle, then returns to IDLE.
REQ-027 SHALL give status register i (8 bits) the following write behaviour:
- Loaded from DATA on every rising CLK edge while io_cyc & !WR_B & ADR==STAT_ADR+i.
- The final value is the one sampled on the last strobe cycle.
REQ-028 SHALL read back status register i onto DATA combinationally while io_cyc & !RD_B & ADR==STAT_ADR+i.
- Register 0 reads as {!TUBE_INT_B, stored[6:0]}.
- Bit 7 of register 0 is read-only.
REQ-029 SHALL drive INT_B to 0 when !TUBE_INT_B & stat0[0], and to Z otherwise.
REQ-030 SHALL leave DATA as Z for all other cycles.
REQ-031 SHALL keep status register access independent of the FSM: it never asserts WAIT_B.

Reset
REQ-032 SHALL, while RESET_B is 0, immediately force:
- FSM to IDLE; TUBE_PHI2 to 0; phase counter to 0.
- Read latch and all status registers to 8'h00.
- WAIT_B, INT_B, DATA and TUBE_DATA to Z.
- TUBE_CS_B and TUBE_RNW_B remain combinational.
REQ-033 SHALL behave on a reset asserted mid-access (any state) per REQ-032 with no PHI2 completion; after release, a new access begins only on a fresh tube_acc.

Verification
REQ-034 SHALL be verified with Tube write: PHI2_CYC=1, OUT (FA81),5A -> WAIT_B low 3 cycles, TUBE_PHI2 high 1 cycle, TUBE_DATA=5A during PHI2, TUBE_CS_B low.
REQ-035 SHALL be verified with Tube read: PHI2_CYC=3, Tube returns 0xC3 -> TUBE_PHI2 high exactly 3 cycles, DATA=C3 in HOLD.
REQ-036 SHALL be verified with status registers: NSTAT=2, write 0x81 to FFF9 and 0x7E to FFFA -> reads return 0x01 (TUBE_INT_B high) and 0x7E; with TUBE_INT_B low, read of FFF9 returns 0x81.
REQ-037 SHALL be verified with interrupt gating: stat0=0x00 and TUBE_INT_B low -> INT_B Z; stat0=0x01 -> INT_B 0; TUBE_INT_B high -> INT_B Z.
REQ-038 SHALL be verified with early abort and M1: IOREQ_B rises during PHI2H -> full PHI2_CYC pulse then IDLE; IOREQ_B and M1_B both low at FA80 -> no FSM start, WAIT_B Z.
REQ-039 SHALL be verified with reset mid-PHI2H: TUBE_PHI2 and WAIT_B release asynchronously, status registers read 0x00.
